// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction ROM port, decode-side IF/ID outputs,
// decode feedback (stall, redirect) and performance counters.
// master: the fetch stage. slave: the ROM/decode environment.
interface fetch_stage_if #(
  parameter int unsigned PC_W   = 12,
  parameter int unsigned INST_W = 16
);
  logic              stallD;
  logic              branch_taken;
  logic [PC_W-1:0]   PC_branch;
  logic              o_imem_en;
  logic [PC_W-1:0]   o_imem_addr;
  logic [INST_W-1:0] i_imem_data;
  logic [INST_W-1:0] o_inst;
  logic [PC_W-1:0]   o_pcD;
  logic              o_validD;
  logic              o_halted;
  logic [15:0]       o_perf_fetched;
  logic [15:0]       o_perf_bubbles;

  modport master (
    input  stallD, branch_taken, PC_branch, i_imem_data,
    output o_imem_en, o_imem_addr, o_inst, o_pcD, o_validD, o_halted,
           o_perf_fetched, o_perf_bubbles
  );

  modport slave (
    output stallD, branch_taken, PC_branch, i_imem_data,
    input  o_imem_en, o_imem_addr, o_inst, o_pcD, o_validD, o_halted,
           o_perf_fetched, o_perf_bubbles
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, reads a synchronous ROM, holds the
// IF/ID register with a one-entry skid buffer for decode stalls, applies branch
// redirects and stops fetching after a HALT opcode.
// Optional build macro FETCH_PERF_EN adds saturating fetched/bubble counters;
// without it the counter outputs are tied to zero.
module fetch_stage #(
  parameter int unsigned     PC_W     = 12,
  parameter int unsigned     INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  typedef enum logic [0:0] {StRun, StHalt} state_t;

  state_t            state, stateNext;
  logic [PC_W-1:0]   pcF, pcFNext;
  logic              reqValid, reqValidNext;
  logic [PC_W-1:0]   reqPc, reqPcNext;
  logic              skidValid, skidValidNext;
  logic [INST_W-1:0] skidInst, skidInstNext;
  logic [PC_W-1:0]   skidPc, skidPcNext;
  logic [INST_W-1:0] instD, instDNext;
  logic [PC_W-1:0]   pcD, pcDNext;
  logic              validD, validDNext;
  logic              issue;
  logic              loadValid;

  // Next-state: issue, capture/skid, redirect and RUN->HALT decisions.
  always_comb begin
    stateNext     = state;
    pcFNext       = pcF;
    reqPcNext     = reqPc;
    skidValidNext = skidValid;
    skidInstNext  = skidInst;
    skidPcNext    = skidPc;
    instDNext     = instD;
    pcDNext       = pcD;
    validDNext    = validD;
    loadValid     = 1'b0;

    // A full skid blocks issue so at most one word is ever outstanding past IF/ID.
    issue = (state == StRun) && !bus.stallD && !bus.branch_taken && !skidValid;
    reqValidNext = issue;
    if (issue) begin
      reqPcNext = pcF;
      pcFNext   = pcF + PC_W'(1);
    end

    if (state == StRun) begin
      if (bus.branch_taken) begin
        // Redirect beats stall and capture: flush everything in flight.
        pcFNext       = bus.PC_branch;
        reqValidNext  = 1'b0;
        skidValidNext = 1'b0;
        instDNext     = '0;
        validDNext    = 1'b0;
      end else if (skidValid) begin
        if (!bus.stallD) begin
          instDNext     = skidInst;
          pcDNext       = skidPc;
          validDNext    = 1'b1;
          skidValidNext = 1'b0;
          loadValid     = 1'b1;
        end
      end else if (reqValid) begin
        if (!bus.stallD) begin
          instDNext  = bus.i_imem_data;
          pcDNext    = reqPc;
          validDNext = 1'b1;
          loadValid  = 1'b1;
        end else begin
          skidInstNext  = bus.i_imem_data;
          skidPcNext    = reqPc;
          skidValidNext = 1'b1;
        end
      end else if (!bus.stallD) begin
        instDNext  = '0;
        validDNext = 1'b0;
      end

      if (loadValid && (instDNext[INST_W-1 -: 4] == HALT_OP)) begin
        stateNext = StHalt;
      end
    end
  end

  // State registers with synchronous reset; in-flight ROM data is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StRun;
      pcF       <= RESET_PC;
      reqValid  <= 1'b0;
      reqPc     <= '0;
      skidValid <= 1'b0;
      skidInst  <= '0;
      skidPc    <= '0;
      instD     <= '0;
      pcD       <= '0;
      validD    <= 1'b0;
    end else begin
      state     <= stateNext;
      pcF       <= pcFNext;
      reqValid  <= reqValidNext;
      reqPc     <= reqPcNext;
      skidValid <= skidValidNext;
      skidInst  <= skidInstNext;
      skidPc    <= skidPcNext;
      instD     <= instDNext;
      pcD       <= pcDNext;
      validD    <= validDNext;
    end
  end

  assign bus.o_imem_en   = issue;
  assign bus.o_imem_addr = pcF;
  assign bus.o_inst      = instD;
  assign bus.o_pcD       = pcD;
  assign bus.o_validD    = validD;
  assign bus.o_halted    = (state == StHalt);

`ifdef FETCH_PERF_EN
  logic [15:0] perfFetched, perfBubbles;

  // Saturating counters: valid IF/ID loads and cycles showing a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      perfFetched <= '0;
      perfBubbles <= '0;
    end else begin
      if (loadValid && (perfFetched != 16'hFFFF)) perfFetched <= perfFetched + 16'd1;
      if (!validD && (perfBubbles != 16'hFFFF)) perfBubbles <= perfBubbles + 16'd1;
    end
  end

  assign bus.o_perf_fetched = perfFetched;
  assign bus.o_perf_bubbles = perfBubbles;
`else
  assign bus.o_perf_fetched = 16'h0000;
  assign bus.o_perf_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural synchronous ROM, expected-PC
// scoreboard popped on each new valid IF/ID load, plus cycle-exact latency checks.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;

  fetch_stage_if #(.PC_W(12), .INST_W(16)) bus ();

  fetch_stage #(
    .PC_W(12), .INST_W(16), .RESET_PC(12'h000), .HALT_OP(4'hF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] rom [0:4095];
  logic [27:0] expQ [$];
  bit          monOn   = 1'b0;
  bit          newLoad = 1'b0;
  int          fetModel = 0;
  int          bubModel = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] pc);
    expQ.push_back({pc, rom[pc]});
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    expQ.delete();
    reset = 1'b0;
    monOn = 1'b1;
  endtask

  task automatic checkPerf();
`ifdef FETCH_PERF_EN
    checkVal("perf_fetched", 32'(bus.o_perf_fetched), 32'(fetModel));
    checkVal("perf_bubbles", 32'(bus.o_perf_bubbles), 32'(bubModel));
`else
    checkVal("perf_fetched_off", 32'(bus.o_perf_fetched), 32'h0);
    checkVal("perf_bubbles_off", 32'(bus.o_perf_bubbles), 32'h0);
`endif
  endtask

  task automatic endScenario(input string tag);
    @(negedge clk);
    #1;
    monOn = 1'b0;
    checkVal(tag, 32'(expQ.size()), 32'h0);
    checkPerf();
  endtask

  // Synchronous ROM: data valid the cycle after the read request.
  always @(posedge clk) begin
    if (bus.o_imem_en) bus.i_imem_data <= rom[bus.o_imem_addr];
  end

  // Pre-edge sampling: did this edge load IF/ID, and perf bubble model.
  initial forever begin
    @(posedge clk);
    newLoad = !reset && !bus.stallD && !bus.o_halted && !bus.branch_taken;
    if (reset) begin
      bubModel = 0;
      fetModel = 0;
    end else if (!bus.o_validD && bubModel < 65535) begin
      bubModel++;
    end
  end

  // Scoreboard: every freshly loaded valid instruction must be the next expected one.
  initial forever begin
    @(negedge clk);
    if (newLoad && bus.o_validD) begin
      if (fetModel < 65535) fetModel++;
      if (monOn) begin
        if (expQ.size() == 0) begin
          checkVal("spurious_valid", 32'(bus.o_validD), 32'h0);
        end else begin
          logic [27:0] e;
          e = expQ.pop_front();
          checkVal("sb_pcD", 32'(bus.o_pcD), 32'(e[27:16]));
          checkVal("sb_inst", 32'(bus.o_inst), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 16'(16'h1000 + a);
    reset            = 1'b1;
    bus.stallD       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.PC_branch    = '0;

    // Reset state and first-fetch latency.
    doReset();
    checkVal("rst_validD", 32'(bus.o_validD), 32'h0);
    checkVal("rst_inst", 32'(bus.o_inst), 32'h0);
    checkVal("rst_pcD", 32'(bus.o_pcD), 32'h0);
    checkVal("rst_halted", 32'(bus.o_halted), 32'h0);
    checkVal("rst_en", 32'(bus.o_imem_en), 32'h1);
    checkVal("rst_addr", 32'(bus.o_imem_addr), 32'h0);
    checkPerf();
    for (int p = 0; p < 5; p++) push(12'(p));
    tick();
    checkVal("lat_c1_valid", 32'(bus.o_validD), 32'h0);
    tick();
    checkVal("lat_c2_valid", 32'(bus.o_validD), 32'h1);
    checkVal("lat_c2_inst", 32'(bus.o_inst), 32'h1000);
    checkVal("lat_c2_pcD", 32'(bus.o_pcD), 32'h0);
    tick();
    checkVal("seq_inst1", 32'(bus.o_inst), 32'h1001);
    tick();
    checkVal("seq_inst2", 32'(bus.o_inst), 32'h1002);

    // Three-cycle stall with pc 3 in flight.
    bus.stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal("stall_en", 32'(bus.o_imem_en), 32'h0);
      checkVal("stall_pcD", 32'(bus.o_pcD), 32'h2);
      checkVal("stall_valid", 32'(bus.o_validD), 32'h1);
      tick();
    end
    bus.stallD = 1'b0;
    #1;
    checkVal("release_noissue", 32'(bus.o_imem_en), 32'h0);
    tick();
    checkVal("release_pcD3", 32'(bus.o_pcD), 32'h3);
    checkVal("release_en", 32'(bus.o_imem_en), 32'h1);
    checkVal("release_addr", 32'(bus.o_imem_addr), 32'h4);
    tick();
    checkVal("release_bubble", 32'(bus.o_validD), 32'h0);
    tick();
    checkVal("release_pcD4", 32'(bus.o_pcD), 32'h4);

    // Redirect while pc 5 is in flight.
    push(12'h040);
    bus.branch_taken = 1'b1;
    bus.PC_branch    = 12'h040;
    #1;
    checkVal("br_en_n", 32'(bus.o_imem_en), 32'h0);
    tick();
    bus.branch_taken = 1'b0;
    #1;
    checkVal("br_bubble_n1", 32'(bus.o_validD), 32'h0);
    checkVal("br_addr_n1", 32'(bus.o_imem_addr), 32'h040);
    checkVal("br_en_n1", 32'(bus.o_imem_en), 32'h1);
    tick();
    checkVal("br_bubble_n2", 32'(bus.o_validD), 32'h0);
    tick();
    checkVal("br_valid_n3", 32'(bus.o_validD), 32'h1);
    checkVal("br_pcD_n3", 32'(bus.o_pcD), 32'h040);

    // Redirect during a stall with the skid full.
    bus.stallD = 1'b1;
    tick();
    push(12'h080);
    push(12'h081);
    push(12'h082);
    bus.branch_taken = 1'b1;
    bus.PC_branch    = 12'h080;
    #1;
    checkVal("bs_en_n", 32'(bus.o_imem_en), 32'h0);
    tick();
    bus.branch_taken = 1'b0;
    bus.stallD       = 1'b0;
    #1;
    checkVal("bs_bubble_n1", 32'(bus.o_validD), 32'h0);
    checkVal("bs_addr_n1", 32'(bus.o_imem_addr), 32'h080);
    checkVal("bs_en_n1", 32'(bus.o_imem_en), 32'h1);
    tick();
    tick();
    checkVal("bs_valid_n3", 32'(bus.o_validD), 32'h1);
    checkVal("bs_pcD_n3", 32'(bus.o_pcD), 32'h080);
    tick();
    tick();
    checkVal("bs_pcD_n5", 32'(bus.o_pcD), 32'h082);
    endScenario("q_empty_run");

    // HALT opcode at pc 3.
    rom[3] = 16'hF000;
    doReset();
    for (int p = 0; p < 4; p++) push(12'(p));
    for (int i = 0; i < 4; i++) tick();
    checkVal("halt_pre", 32'(bus.o_halted), 32'h0);
    tick();
    checkVal("halt_set", 32'(bus.o_halted), 32'h1);
    checkVal("halt_en", 32'(bus.o_imem_en), 32'h0);
    checkVal("halt_pcD", 32'(bus.o_pcD), 32'h3);
    checkVal("halt_inst", 32'(bus.o_inst), 32'hF000);
    bus.branch_taken = 1'b1;
    bus.PC_branch    = 12'h100;
    #1;
    checkVal("halt_br_en", 32'(bus.o_imem_en), 32'h0);
    tick();
    bus.branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal("halt_hold_en", 32'(bus.o_imem_en), 32'h0);
      checkVal("halt_hold", 32'(bus.o_halted), 32'h1);
      checkVal("halt_no_pc4", 32'(bus.o_validD && bus.o_pcD == 12'h4), 32'h0);
      tick();
    end
    endScenario("q_empty_halt");

    // Reset leaves HALT and restarts at pc 0; then fetch across the PC wrap.
    rom[3] = 16'h1003;
    doReset();
    checkVal("restart_halted", 32'(bus.o_halted), 32'h0);
    checkVal("restart_en", 32'(bus.o_imem_en), 32'h1);
    checkVal("restart_addr", 32'(bus.o_imem_addr), 32'h0);
    push(12'h000);
    tick();
    tick();
    checkVal("restart_pcD", 32'(bus.o_pcD), 32'h0);
    checkVal("restart_inst", 32'(bus.o_inst), 32'h1000);
    push(12'hFFD);
    push(12'hFFE);
    push(12'hFFF);
    push(12'h000);
    push(12'h001);
    bus.branch_taken = 1'b1;
    bus.PC_branch    = 12'hFFD;
    tick();
    bus.branch_taken = 1'b0;
    #1;
    checkVal("wrap_bubble", 32'(bus.o_validD), 32'h0);
    tick();
    tick();
    checkVal("wrap_pcD_ffd", 32'(bus.o_pcD), 32'hFFD);
    tick();
    tick();
    checkVal("wrap_pcD_fff", 32'(bus.o_pcD), 32'hFFF);
    tick();
    checkVal("wrap_pcD_000", 32'(bus.o_pcD), 32'h000);
    checkVal("wrap_valid", 32'(bus.o_validD), 32'h1);
    checkVal("wrap_inst", 32'(bus.o_inst), 32'h1000);
    tick();
    endScenario("q_empty_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the decode stage. Owns the 12-bit fetch PC and issues reads to a synchronous instruction ROM. Holds the IF/ID pipeline register (instruction, PC, valid) that feeds decode's instruction and PC inputs. Absorbs decode stalls with a one-entry skid buffer, applies branch redirects from decode's PC_branch, and stops fetching after a HALT opcode.

Parameters:
PC_W, 12, fetch PC / branch target width
INST_W, 16, instruction width
RESET_PC, 12'h000, first fetch address after reset
HALT_OP, 4'hF, opcode (inst[15:12]) that stops fetch

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
stallD  in  1  decode cannot accept; hold IF/ID
branch_taken  in  1  one-cycle redirect pulse from decode
PC_branch  in  PC_W  redirect target from decode
o_imem_en  out  1  ROM read request this cycle (combinational)
o_imem_addr  out  PC_W  ROM read address, = pcF (combinational)
i_imem_data  in  INST_W  ROM data, valid the cycle after o_imem_en=1
o_inst  out  INST_W  IF/ID instruction to decode
o_pcD  out  PC_W  IF/ID PC to decode
o_validD  out  1  IF/ID holds a real instruction
o_halted  out  1  fetch stopped by HALT_OP
o_perf_fetched  out  16  instructions delivered (see Optional Feature)
o_perf_bubbles  out  16  cycles with o_validD=0 (see Optional Feature)

Behaviour:
- Interface: single clock clk; reset is synchronous, active-high.
- Reset values: pcF=RESET_PC; o_inst=16'h0000; o_pcD=0; o_validD=0; o_halted=0; req_valid=0; skid_valid=0; state=RUN; perf counters=0.
- Reset mid-operation: all state returns to the reset values at that edge. In-flight ROM data is discarded.
- States: RUN and HALT. RUN->HALT when an instruction with inst[15:12]==HALT_OP is loaded into IF/ID in the same edge as validD=1. HALT is left only by reset.
- Issue: o_imem_en = (state==RUN) & ~stallD & ~branch_taken & ~skid_valid_next_blocked. Simplified rule: issue iff RUN, no stall, no redirect, and the skid buffer is empty. On issue: req_valid<=1, req_pc<=pcF, pcF<=pcF+1. pcF wraps 12'hFFF->12'h000.
- Capture: if req_valid and there is no redirect:
  - no stall: IF/ID<={i_imem_data, req_pc, 1}.
  - stall: skid<={i_imem_data, req_pc}, skid_valid<=1.
- Stall release: if skid_valid and ~stallD, IF/ID<=skid and skid_valid<=0. No ROM issue that cycle; issue resumes the next cycle.
- Stall with nothing arriving: IF/ID holds all fields unchanged, including o_validD.
- No instruction available and not stalled: o_validD<=0 and o_inst<=0, so decode sees a bubble.
- Latency: issue at cycle N; ROM data at N+1; visible on o_inst at N+2. Steady-state throughput is 1 instruction per cycle.
- Redirect (branch_taken=1) has priority over stall and capture:
  - pcF<=PC_branch; req_valid<=0; skid_valid<=0.
  - IF/ID<=bubble (o_validD=0, o_inst=0).
  - No issue that cycle. The target is issued at N+1 and is visible with o_validD=1 at N+3.
- Redirect and HALT capture in the same cycle: redirect wins; the halt instruction is flushed and the state stays RUN.
- Redirect while in HALT: ignored.
- HALT: o_imem_en=0, o_halted=1. The halt instruction stays in IF/ID, obeying stallD. Data arriving after the halt capture is discarded.

Optional Feature:
FETCH_PERF_EN defined:
- o_perf_fetched increments on each IF/ID load with valid=1.
- o_perf_bubbles increments each cycle o_validD=0.
- Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
Undefined: both outputs are tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset, ROM[a]=16'h1000+a, 5 free-running cycles -> o_validD first 1 at cycle 2 after reset release with o_inst=16'h1000, o_pcD=0. Then 16'h1001, 16'h1002 on consecutive cycles.
- stallD=1 for 3 cycles mid-stream (IF/ID holds pc=2) -> o_inst and o_pcD are frozen, o_imem_en=0, and the in-flight pc=3 word lands in skid. After release: pc=3 next, then pc=4 with no gap other than one bubble; no instruction lost or duplicated.
- branch_taken=1 with PC_branch=12'h040 while pc 5/6 are in flight -> pc 5/6 never reach o_validD=1. o_imem_addr=12'h040 at N+1; o_pcD=12'h040 with o_validD=1 at N+3.
- branch_taken and stallD both high with skid full -> skid dropped and the redirect is taken exactly as in the previous scenario.
- ROM[3]=16'hF000 -> o_halted=1 after pc=3 is captured and o_imem_en stays 0. A later branch_taken pulse causes no fetch. Reset then restarts fetch at pc 0.
- Fetch through pcF=12'hFFF -> next o_pcD=12'h000. With FETCH_PERF_EN, o_perf_fetched equals the valid IF/ID load count and o_perf_bubbles equals the invalid cycles.
